// File: rtl/dispense_pump_sequencer.sv
// Load-button to pump-dose sequencer.
// Each raw button is synchronised, debounced and edge-detected; every press
// becomes one pending request, requests are queued in arrival order (lowest
// channel first on a tie) and an IDLE/DOSE/GAP sequencer runs one pump at a
// time with a dead gap after every dose.
module dispense_pump_sequencer #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int DOSE_CYC     = 100,
    parameter int GAP_CYC      = 8,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 8
) (
    input  logic                     clk,
    input  logic                     RESET,
    input  logic                     load0,
    input  logic                     load1,
    input  logic                     load2,
    input  logic                     load3,
    output logic                     p0,
    output logic                     p1,
    output logic                     p2,
    output logic                     p3,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     done,
    output logic                     drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int QC_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DOSE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Input path
    logic [3:0]            load_s;
    logic [3:0]            sync1_q;
    logic [3:0]            sync2_q;
    logic [CNT_W-1:0]      deb_cnt_q [4];
    logic [3:0]            deb_q;
    logic [3:0]            deb_prev_q;
    logic [3:0]            rise_s;

    // Pending set and arbitration
    logic [3:0]            pend_q;
    logic [1:0]            grant_id_s;
    logic [3:0]            grant_s;
    logic                  push_s;
    logic                  drop_q;

    // Request FIFO
    logic [1:0]            mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [QC_W-1:0]       count_q;
    logic                  full_s;
    logic                  pop_s;
    logic [1:0]            head_s;

    // Sequencer
    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [3:0]            p_q;
    logic                  done_q;

    assign load_s = {load3, load2, load1, load0};

    // Two-flop synchroniser for the asynchronous button levels
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= load_s;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i] <= '0;
            end
            deb_q      <= 4'b0000;
            deb_prev_q <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != deb_q[i]) begin
                    if (deb_cnt_q[i] == CNT_W'(DEBOUNCE_CYC - 1)) begin
                        deb_q[i]     <= ~deb_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
            deb_prev_q <= deb_q;
        end
    end

    // Only rising edges of the debounced level are presses
    assign rise_s = deb_q & ~deb_prev_q;

    // Lowest-index pending channel wins the single FIFO write slot
    always_comb begin
        grant_id_s = 2'd0;
        if (pend_q[0]) begin
            grant_id_s = 2'd0;
        end else if (pend_q[1]) begin
            grant_id_s = 2'd1;
        end else if (pend_q[2]) begin
            grant_id_s = 2'd2;
        end else begin
            grant_id_s = 2'd3;
        end
    end

    assign full_s  = (count_q == QC_W'(DEPTH));
    assign pop_s   = (state_q == ST_IDLE) && (count_q != '0);
    assign push_s  = (|pend_q) && (!full_s || pop_s);
    assign grant_s = push_s ? (4'b0001 << grant_id_s) : 4'b0000;
    assign head_s  = mem_q[rd_ptr_q];

    // Pending bits: set on a press, cleared when written to the FIFO; a press
    // on a channel that is already pending is discarded and reported
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            pend_q <= 4'b0000;
            drop_q <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~grant_s) | (rise_s & ~pend_q);
            drop_q <= |(rise_s & pend_q);
        end
    end

    // Circular request FIFO holding 2-bit channel IDs
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'd0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= grant_id_s;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + QC_W'(1);
                2'b01:   count_q <= count_q - QC_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Dose sequencer: IDLE pops, DOSE holds one pump, GAP keeps all pumps low
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            p_q     <= 4'b0000;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        p_q     <= 4'b0001 << head_s;
                        cnt_q   <= CNT_W'(DOSE_CYC - 1);
                        done_q  <= (DOSE_CYC == 1);
                        state_q <= ST_DOSE;
                    end else begin
                        p_q     <= 4'b0000;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_DOSE: begin
                    if (cnt_q == '0) begin
                        p_q     <= 4'b0000;
                        cnt_q   <= CNT_W'(GAP_CYC - 1);
                        done_q  <= 1'b0;
                        state_q <= ST_GAP;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                        done_q  <= (cnt_q == CNT_W'(1));
                        state_q <= ST_DOSE;
                    end
                end
                ST_GAP: begin
                    p_q    <= 4'b0000;
                    done_q <= 1'b0;
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                        state_q <= ST_GAP;
                    end
                end
                default: begin
                    p_q     <= 4'b0000;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign p0      = p_q[0];
    assign p1      = p_q[1];
    assign p2      = p_q[2];
    assign p3      = p_q[3];
    assign done    = done_q;
    assign drop    = drop_q;
    assign q_count = count_q;
    assign busy    = (state_q != ST_IDLE) || (count_q != '0) || (|pend_q);

endmodule

// File: tb/tb_dispense_pump_sequencer.sv
// Bench for dispense_pump_sequencer: a default-parameter instance and a
// small-FIFO instance, both checked every cycle against a queue-based model.
module tb_dispense_pump_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] raw_a = 4'b0000;
    logic [3:0] raw_b = 4'b0000;
    logic [3:0] pa, pb;
    logic       busy_a, done_a, drop_a, busy_b, done_b, drop_b;
    logic [2:0] qc_a;
    logic [1:0] qc_b;

    always #5 clk = ~clk;

    dispense_pump_sequencer u_dut_a (
        .clk(clk), .RESET(reset_n),
        .load0(raw_a[0]), .load1(raw_a[1]), .load2(raw_a[2]), .load3(raw_a[3]),
        .p0(pa[0]), .p1(pa[1]), .p2(pa[2]), .p3(pa[3]),
        .busy(busy_a), .q_count(qc_a), .done(done_a), .drop(drop_a)
    );

    dispense_pump_sequencer #(
        .DEBOUNCE_CYC(1), .DOSE_CYC(50), .GAP_CYC(8), .DEPTH(2), .CNT_W(8)
    ) u_dut_b (
        .clk(clk), .RESET(reset_n),
        .load0(raw_b[0]), .load1(raw_b[1]), .load2(raw_b[2]), .load3(raw_b[3]),
        .p0(pb[0]), .p1(pb[1]), .p2(pb[2]), .p3(pb[3]),
        .busy(busy_b), .q_count(qc_b), .done(done_b), .drop(drop_b)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    bit   sel = 1'b0;
    int   P_DEB = 4, P_DOSE = 100, P_GAP = 8, P_DEPTH = 4;
    int   m_k = 0;
    bit [3:0] m_r1, m_r2, m_lvl, m_arr, m_pend;
    int   m_run [4];
    int   m_q [$];
    bit   m_have, m_drop;
    int   m_dose_start, m_dose_ch, m_next_pop;

    function automatic void model_reset();
        m_r1 = 4'b0; m_r2 = 4'b0; m_lvl = 4'b0; m_arr = 4'b0; m_pend = 4'b0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_q.delete();
        m_have = 1'b0; m_drop = 1'b0;
        m_dose_start = 0; m_dose_ch = 0; m_next_pop = 0;
    endfunction

    function automatic void model_edge(input logic rst_lvl, input logic [3:0] raw);
        bit pop, push;
        int g;
        bit [3:0] pend_n;
        m_k++;
        if (!rst_lvl) begin
            model_reset();
            return;
        end
        pop = (m_k >= m_next_pop) && (m_q.size() > 0);
        g = -1;
        for (int i = 3; i >= 0; i--) if (m_pend[i]) g = i;
        push = (g >= 0) && ((m_q.size() < P_DEPTH) || pop);
        pend_n = m_pend;
        m_drop = 1'b0;
        if (push) pend_n[g] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_arr[i]) begin
                if (m_pend[i]) m_drop = 1'b1;
                else pend_n[i] = 1'b1;
            end
        end
        m_pend = pend_n;
        if (pop) begin
            m_dose_ch    = m_q.pop_front();
            m_dose_start = m_k;
            m_have       = 1'b1;
            m_next_pop   = m_k + P_DOSE + P_GAP + 1;
        end
        if (push) m_q.push_back(g);
        for (int i = 0; i < 4; i++) begin
            m_arr[i] = 1'b0;
            if (m_r2[i] != m_lvl[i]) begin
                m_run[i]++;
                if (m_run[i] == P_DEB) begin
                    m_lvl[i] = ~m_lvl[i];
                    m_run[i] = 0;
                    m_arr[i] = m_lvl[i];
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_r2 = m_r1;
        m_r1 = raw;
    endfunction

    function automatic logic [3:0] exp_p();
        if (m_have && (m_k - m_dose_start) < P_DOSE) return 4'b0001 << m_dose_ch;
        return 4'b0000;
    endfunction

    function automatic logic exp_done();
        return m_have && ((m_k - m_dose_start) == P_DOSE - 1);
    endfunction

    function automatic logic exp_busy();
        return (m_have && ((m_k - m_dose_start) < P_DOSE + P_GAP)) ||
               (m_q.size() > 0) || (m_pend != 4'b0);
    endfunction

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, m_k);
        end
    endtask

    function automatic logic [3:0] obs_p();  return sel ? pb : pa; endfunction
    function automatic logic obs_busy();     return sel ? busy_b : busy_a; endfunction
    function automatic logic obs_done();     return sel ? done_b : done_a; endfunction
    function automatic logic obs_drop();     return sel ? drop_b : drop_a; endfunction
    function automatic int   obs_qc();       return sel ? int'(qc_b) : int'(qc_a); endfunction

    // statistics gathered from observed outputs
    int rise_cnt [4];
    int first_rise [4];
    int high_cnt [4];
    int rise_order [$];
    int rise_edge [$];
    int done_cnt, drop_cnt, q_peak, done_k, busy_fall_k;
    logic [3:0] prev_p = 4'b0;
    logic prev_busy = 1'b0;

    task automatic clear_stats();
        for (int i = 0; i < 4; i++) begin
            rise_cnt[i] = 0; first_rise[i] = -1; high_cnt[i] = 0;
        end
        rise_order.delete(); rise_edge.delete();
        done_cnt = 0; drop_cnt = 0; q_peak = 0; done_k = -1; busy_fall_k = -1;
    endtask

    task automatic compare_all();
        logic [3:0] p;
        p = obs_p();
        check_eq("p", 32'(p), 32'(exp_p()));
        check_eq("done", 32'(obs_done()), 32'(exp_done()));
        check_eq("drop", 32'(obs_drop()), 32'(m_drop));
        check_eq("busy", 32'(obs_busy()), 32'(exp_busy()));
        check_eq("q_count", 32'(obs_qc()), 32'(m_q.size()));
        check_eq("onehot", 32'($countones(p) <= 1), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) high_cnt[i]++;
            if (p[i] && !prev_p[i]) begin
                rise_cnt[i]++;
                if (first_rise[i] < 0) first_rise[i] = m_k;
                rise_order.push_back(i);
                rise_edge.push_back(m_k);
            end
        end
        if (obs_done()) begin done_cnt++; done_k = m_k; end
        if (obs_drop()) drop_cnt++;
        if (obs_qc() > q_peak) q_peak = obs_qc();
        if (prev_busy && !obs_busy()) busy_fall_k = m_k;
        prev_p = p;
        prev_busy = obs_busy();
    endtask

    // one clock: model consumes the inputs at the rising edge, outputs checked at the falling edge
    task automatic step();
        @(posedge clk);
        model_edge(reset_n, sel ? raw_b : raw_a);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (P_DEB + 8) step();
        while (obs_busy() && n < budget) begin
            step();
            n++;
        end
        check_eq("idle_timeout", 32'(obs_busy()), 32'd0);
    endtask

    task automatic check_order(input string tag, input int exp_ch [$]);
        check_eq({tag, "_n"}, 32'(rise_order.size()), 32'(exp_ch.size()));
        for (int i = 0; i < exp_ch.size(); i++)
            check_eq(tag, (i < rise_order.size()) ? 32'(rise_order[i]) : 32'hFFFF_FFFF, 32'(exp_ch[i]));
    endtask

    initial begin
        int start_k;
        model_reset();
        clear_stats();
        @(negedge clk);

        // Reset held while the buttons toggle: everything stays at zero
        reset_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            raw_a = 4'($urandom);
            step();
        end
        // Release with load2 held: a fresh press after the debounce time
        raw_a = 4'b0100;
        clear_stats();
        start_k = m_k + 1;
        reset_n = 1'b1;
        repeat (20) step();
        check_eq("rst_rel_lat", 32'(first_rise[2] - start_k), 32'd8);
        raw_a = 4'b0000;
        wait_idle(400);
        check_eq("rst_rel_doses", 32'(rise_cnt[2]), 32'd1);

        // Single press held for 126 cycles from idle
        clear_stats();
        repeat ($urandom_range(0, 5)) step();
        raw_a = 4'b1000;
        start_k = m_k + 1;
        repeat (126) step();
        raw_a = 4'b0000;
        wait_idle(400);
        check_eq("single_lat", 32'(first_rise[3] - start_k), 32'd8);
        check_eq("single_len", 32'(high_cnt[3]), 32'd100);
        check_eq("single_rises", 32'(rise_cnt[3]), 32'd1);
        check_eq("single_done", 32'(done_cnt), 32'd1);
        check_eq("busy_tail", 32'(busy_fall_k - done_k), 32'd9);

        // Short glitches on load1 never make a press
        clear_stats();
        for (int r = 0; r < 10; r++) begin
            raw_a = 4'b0010;
            repeat (3) step();
            raw_a = 4'b0000;
            repeat ($urandom_range(3, 6)) step();
        end
        wait_idle(200);
        check_eq("glitch_p1", 32'(rise_cnt[1]), 32'd0);
        check_eq("glitch_drop", 32'(drop_cnt), 32'd0);

        // Ordering: load3, then load1 and load0 during the p3 dose
        clear_stats();
        for (int t = 0; t < 80; t++) begin
            raw_a = {t < 20, 1'b0, (t >= 30 && t < 50), (t >= 60)};
            step();
        end
        raw_a = 4'b0000;
        wait_idle(600);
        check_order("order", '{3, 1, 0});
        check_eq("order_gap1", (rise_edge.size() > 1) ? 32'(rise_edge[1] - rise_edge[0]) : 32'd0, 32'd109);
        check_eq("order_gap2", (rise_edge.size() > 2) ? 32'(rise_edge[2] - rise_edge[1]) : 32'd0, 32'd109);
        check_eq("order_qpeak", 32'(q_peak), 32'd2);

        // Simultaneous presses on load0 and load2
        clear_stats();
        raw_a = 4'b0101;
        repeat (20) step();
        raw_a = 4'b0000;
        wait_idle(400);
        check_order("simul", '{0, 2});
        check_eq("simul_done", 32'(done_cnt), 32'd2);
        check_eq("simul_drop", 32'(drop_cnt), 32'd0);

        // Random button activity against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) raw_a[i] = ~raw_a[i];
            step();
        end
        raw_a = 4'b0000;
        wait_idle(3000);

        // Overflow configuration on the second instance
        sel = 1'b1;
        reset_n = 1'b0;
        P_DEB = 1; P_DOSE = 50; P_GAP = 8; P_DEPTH = 2;
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
        repeat (2) step();
        clear_stats();
        for (int r = 0; r < 6; r++) begin
            raw_b = 4'b0001;
            repeat (3) step();
            raw_b = 4'b0000;
            repeat (3) step();
        end
        wait_idle(600);
        check_eq("ovf_doses", 32'(rise_cnt[0]), 32'd4);
        check_eq("ovf_drops", 32'(drop_cnt), 32'd2);
        check_eq("ovf_qpeak", 32'(q_peak), 32'd2);

        // Reset in the middle of a dose with a request still queued
        raw_b = 4'b0001; repeat (3) step();
        raw_b = 4'b0000; repeat (7) step();
        raw_b = 4'b0001; repeat (3) step();
        raw_b = 4'b0000; repeat (12) step();
        check_eq("pre_rst_p0", 32'(pb[0]), 32'd1);
        check_eq("pre_rst_qc", 32'(qc_b), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("async_p0", 32'(pb[0]), 32'd0);
        check_eq("async_qc", 32'(qc_b), 32'd0);
        check_eq("async_busy", 32'(busy_b), 32'd0);
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispense_pump_sequencer.md
Name: dispense_pump_sequencer

Overview:
- Responder side of the dispenser's load-button interface: accepts raw load0..load3 presses and turns each press into exactly one timed pump dose on p0..p3.
- Synchronises and debounces each button, then edge-detects it. Presses are queued in order and pumps run one at a time, with a dead gap between doses.
- Sits between the front-panel inputs and the pump drivers inside the dispenser top. Exposes busy/queue status for the display path.

Parameters:
- DEBOUNCE_CYC, 4: consecutive stable synchronised samples needed before the debounced level changes.
- DOSE_CYC, 100: cycles a pump output stays high per press.
- GAP_CYC, 8: cycles all pumps stay low after a dose.
- DEPTH, 4: request FIFO depth. Power of two, 2..16.
- CNT_W, 8: width of the debounce/dose/gap counters. Must hold max(DEBOUNCE_CYC, DOSE_CYC, GAP_CYC).

Ports:
- clk  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- load0..load3  in  1 each  raw button levels, asynchronous to clk
- p0..p3  out  1 each  pump enables, registered, at most one high
- busy  out  1  high in DOSE or GAP, or while the FIFO/pending set is non-empty
- q_count  out  $clog2(DEPTH)+1  current FIFO occupancy
- done  out  1  one-cycle pulse at end of each dose
- drop  out  1  one-cycle pulse when a press is discarded

Behaviour:
- Reset (RESET=0, async): all outputs 0.
  - Clears FIFO, pending bits, debounced levels, counters. FSM goes to IDLE.
  - Asserting reset mid-dose drops the pump immediately. The in-flight request is discarded.
  - A button still held at reset release counts as a new press after the debounce time.
- Input path, per channel:
  - 2-flop synchroniser.
  - Debounce counter increments while the sync output differs from the debounced level and clears when they are equal. On reaching DEBOUNCE_CYC the debounced level flips and the counter clears.
  - A rising edge of the debounced level sets pending[i]. Falling edges are ignored.
  - A pulse shorter than DEBOUNCE_CYC synchronised cycles produces nothing.
- Pending/arbitration:
  - Each cycle with FIFO not full (or a pop occurring that same cycle), the lowest-index set pending bit is written to the FIFO as a 2-bit channel ID and cleared.
  - At most one write per cycle.
  - A new debounced rising edge on a channel whose pending bit is already set is discarded and drop pulses.
  - A channel already in the FIFO may be queued again.
- FIFO: DEPTH x 2 bits, circular read/write pointers, q_count = occupancy. Simultaneous push and pop leaves q_count unchanged.
- FSM (IDLE, DOSE, GAP):
  - IDLE: if the FIFO is non-empty, pop, drive the popped channel's p high from the next cycle, load the dose counter, go to DOSE.
  - DOSE: p high for exactly DOSE_CYC cycles. On the last cycle, pulse done, drop p, go to GAP.
  - GAP: all p low for exactly GAP_CYC cycles, then IDLE.
  - IDLE is always spent for at least one cycle before the next pop.
- Latency, idle block: a raw rise first sampled at edge N gives p high after edge N+DEBOUNCE_CYC+4.
  - Sync: 2 cycles.
  - Debounce: DEBOUNCE_CYC cycles.
  - Pending, FIFO, pop: 1 cycle each, less the overlap with the last sync stage.
- Dose period per request: DOSE_CYC + GAP_CYC + 1 cycles.
- busy is combinational from registered state.
- No pump is ever high in GAP or IDLE. Two pumps are never high together.

Test Plan:
- Reset: hold RESET=0 for 5 cycles while load0..3 toggle -> p0..p3, busy, done, drop, q_count all 0. Releasing RESET with load2 held -> p2 rises DEBOUNCE_CYC+4=8 cycles after release.
- Single press: defaults, load3=1 for 126 cycles from idle -> p3 high 8 edges after first sample, exactly 100 cycles. done pulses once at the fall. busy drops 9 cycles after done. No second dose on release.
- Glitch rejection: load1 high for 3 cycles, repeated 10 times with 3-cycle gaps -> p1 never asserts, drop stays 0.
- Ordering: load3 pressed, then load1 and load0 pressed 30 and 60 cycles later during the p3 dose -> doses run p3, p1, p0. q_count peaks at 2. 109 cycles separate successive pump rises.
- Simultaneous: load0 and load2 rise in the same cycle -> p0 dose first, then p2. Two done pulses, drop 0.
- Overflow: DEPTH=2, DEBOUNCE_CYC=1, DOSE_CYC=50. Press load0 six times, 6 cycles apart, while busy -> q_count saturates at 2, pending[0] holds one more, further presses pulse drop. Exactly 4 p0 doses total. Then assert RESET mid-dose -> p0 falls asynchronously and q_count=0.
